// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: two-master AXI-style read arbiter in front of one memory
// slave. Master 0 is the L2 cache, master 1 the secondary read master.
// Exactly one burst is outstanding at the slave. Arbitration is round-robin
// with a 1-bit preference pointer. Defining AXI_ARB_FIXED_PRIORITY_EN
// switches to fixed priority, where master 0 always wins when it requests.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; pick a winner when any master requests
// ADDR  | forward granted master's address to slave, wait for s_arready
// DATA  | forward read beats to granted master until the last one
module axi_read_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  m_arvalid,
  input  logic [63:0] m_araddr,
  input  logic [15:0] m_arlen,
  output logic [1:0]  m_arready,
  output logic [1:0]  m_rvalid,
  input  logic [1:0]  m_rready,
  output logic [31:0] m_rdata,
  output logic [31:0] s_araddr,
  output logic [7:0]  s_arlen,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic        s_rvalid,
  input  logic [31:0] s_rdata,
  output logic        s_rready,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [7:0]  cnt_q, cnt_d;
`ifndef AXI_ARB_FIXED_PRIORITY_EN
  logic        ptr_q, ptr_d;
`endif

  logic        gidx;
  logic        win;
  logic [31:0] sel_addr;
  logic [7:0]  sel_len;
  logic        sel_rready;

  // Decode the granted master and mux its request fields.
  always_comb begin
    gidx       = grant_q[1];
    sel_addr   = gidx ? m_araddr[63:32] : m_araddr[31:0];
    sel_len    = gidx ? m_arlen[15:8]   : m_arlen[7:0];
    sel_rready = gidx ? m_rready[1]     : m_rready[0];
  end

  // Winner selection; only meaningful when some master requests.
  always_comb begin
`ifdef AXI_ARB_FIXED_PRIORITY_EN
    win = m_arvalid[0] ? 1'b0 : 1'b1;
`else
    if (ptr_q) win = m_arvalid[1] ? 1'b1 : 1'b0;
    else       win = m_arvalid[0] ? 1'b0 : 1'b1;
`endif
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      cnt_q   <= 8'd0;
`ifndef AXI_ARB_FIXED_PRIORITY_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
`ifndef AXI_ARB_FIXED_PRIORITY_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Next-state logic: grant, address handshake, beat counting.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
`ifndef AXI_ARB_FIXED_PRIORITY_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|m_arvalid) begin
          grant_d = win ? 2'b10 : 2'b01;
          state_d = ADDR;
        end
      end
      ADDR: begin
        // s_arvalid is always high in ADDR, so s_arready alone completes it.
        if (s_arready) begin
          cnt_d   = sel_len;
          state_d = DATA;
        end
      end
      DATA: begin
        if (s_rvalid && sel_rready) begin
          if (cnt_q == 8'd0) begin
            state_d = IDLE;
            grant_d = 2'b00;
`ifndef AXI_ARB_FIXED_PRIORITY_EN
            ptr_d   = ~gidx;
`endif
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // Outputs: pure routing from state; forced quiet while reset is held low
  // so an abandoned burst never forwards another beat.
  always_comb begin
    m_arready = 2'b00;
    m_rvalid  = 2'b00;
    s_araddr  = 32'd0;
    s_arlen   = 8'd0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    grant     = 2'b00;
    m_rdata   = s_rdata;
    if (reset) begin
      grant = grant_q;
      case (state_q)
        ADDR: begin
          s_arvalid       = 1'b1;
          s_araddr        = sel_addr;
          s_arlen         = sel_len;
          m_arready[gidx] = s_arready;
        end
        DATA: begin
          m_rvalid[gidx] = s_rvalid;
          s_rready       = sel_rready;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: single burst, contention,
// backpressure, 256-beat burst and mid-burst reset.
module tb_axi_read_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  m_arvalid;
  logic [63:0] m_araddr;
  logic [15:0] m_arlen;
  logic [1:0]  m_arready;
  logic [1:0]  m_rvalid;
  logic [1:0]  m_rready;
  logic [31:0] m_rdata;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic        s_arvalid;
  logic        s_arready;
  logic        s_rvalid;
  logic [31:0] s_rdata;
  logic        s_rready;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;
  int nb0 = 0, nb1 = 0, nbs = 0, viol = 0;
  int b0, b1, bs, v, n;

`ifdef AXI_ARB_FIXED_PRIORITY_EN
  localparam logic [1:0] EXP_SECOND = 2'b01;
`else
  localparam logic [1:0] EXP_SECOND = 2'b10;
`endif

  axi_read_arbiter dut (
    .clk(clk), .reset(reset),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rdata(m_rdata),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid),
    .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .s_rready(s_rready), .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat monitor: counts accepted beats and misrouted rvalid.
  always @(posedge clk) begin
    if (s_rvalid && s_rready) nbs <= nbs + 1;
    if (m_rvalid[0] && m_rready[0]) nb0 <= nb0 + 1;
    if (m_rvalid[1] && m_rready[1]) nb1 <= nb1 + 1;
    if (m_rvalid[0] && grant != 2'b01) viol <= viol + 1;
    if (m_rvalid[1] && grant != 2'b10) viol <= viol + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_grant(input int maxc, input string tag);
    int k = 0;
    while (grant == 2'b00 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_grant_timeout"}, (grant != 2'b00), 1);
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int k = 0;
    while (grant != 2'b00 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_idle_timeout"}, (grant == 2'b00), 1);
  endtask

  initial begin
    reset = 1'b0; m_arvalid = 2'b00; m_araddr = 64'd0; m_arlen = 16'd0;
    m_rready = 2'b00; s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_arready", m_arready, 2'b00);
    chk("rst_rvalid", m_rvalid, 2'b00);
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_s_rready", s_rready, 0);
    reset = 1'b1;

    // Single burst: m0 addr 0x100 len 3
    m_arvalid = 2'b01; m_araddr[31:0] = 32'h100; m_arlen[7:0] = 8'd3;
    #1;
    chk("t1_idle_grant", grant, 2'b00);
    chk("t1_idle_s_arvalid", s_arvalid, 0);
    @(negedge clk);
    chk("t1_grant", grant, 2'b01);
    chk("t1_s_arvalid", s_arvalid, 1);
    chk("t1_s_araddr", s_araddr, 32'h100);
    chk("t1_s_arlen", s_arlen, 8'd3);
    chk("t1_arready_wait", m_arready, 2'b00);
    m_arvalid = 2'b00; s_arready = 1'b1;
    #1;
    chk("t1_arready", m_arready, 2'b01);
    b0 = nb0;
    s_rvalid = 1'b1; m_rready = 2'b01; s_rdata = 32'hCAFE0001;
    @(negedge clk);
    chk("t1_data_s_arvalid", s_arvalid, 0);
    chk("t1_data_rvalid", m_rvalid, 2'b01);
    chk("t1_rdata", m_rdata, 32'hCAFE0001);
    s_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t1_stall_beats", nb0 - b0, 0);
    chk("t1_stall_grant", grant, 2'b01);
    s_rvalid = 1'b1;
    wait_idle(20, "t1");
    chk("t1_beats", nb0 - b0, 4);
    chk("t1_idle_s_rready", s_rready, 0);

    // Contention: both request from reset, len 0 each
    do_reset();
    m_arvalid = 2'b11; m_araddr = {32'hB0, 32'hA0}; m_arlen = 16'h0000;
    m_rready = 2'b11; s_rvalid = 1'b1; s_arready = 1'b1;
    wait_grant(5, "t2a");
    chk("t2_first", grant, 2'b01);
    chk("t2_first_addr", s_araddr, 32'hA0);
    wait_idle(10, "t2a");
    wait_grant(5, "t2b");
    chk("t2_second", grant, EXP_SECOND);
    chk("t2_second_addr", s_araddr, (EXP_SECOND == 2'b10) ? 32'hB0 : 32'hA0);
    wait_idle(10, "t2b");
    wait_grant(5, "t2c");
    chk("t2_third", grant, 2'b01);
    m_arvalid = 2'b00;
    wait_idle(10, "t2c");

    // Backpressure: m1 len 7, m_rready[1] toggling
    do_reset();
    m_arvalid = 2'b10; m_araddr[63:32] = 32'h300; m_arlen[15:8] = 8'd7;
    m_rready = 2'b01; s_rvalid = 1'b1;
    wait_grant(5, "t3");
    chk("t3_grant", grant, 2'b10);
    chk("t3_arready", m_arready, 2'b10);
    m_arvalid = 2'b00;
    b0 = nb0; b1 = nb1; v = viol;
    n = 0;
    while (grant != 2'b00 && n < 60) begin
      @(negedge clk);
      m_rready[1] = ~m_rready[1];
      n++;
    end
    chk("t3_done", grant, 2'b00);
    chk("t3_beats_m1", nb1 - b1, 8);
    chk("t3_beats_m0", nb0 - b0, 0);
    chk("t3_misroute", viol - v, 0);

    // Max burst: len 255
    do_reset();
    m_arvalid = 2'b01; m_arlen[7:0] = 8'hFF; m_rready = 2'b01; s_rvalid = 1'b1;
    wait_grant(5, "t4");
    chk("t4_s_arlen", s_arlen, 8'hFF);
    m_arvalid = 2'b00;
    b0 = nb0; bs = nbs;
    wait_idle(400, "t4");
    chk("t4_beats_m0", nb0 - b0, 256);
    chk("t4_beats_s", nbs - bs, 256);
    repeat (4) @(negedge clk);
    chk("t4_no_extra", nbs - bs, 256);
    chk("t4_idle_grant", grant, 2'b00);

    // Reset during beat 2 of a 4-beat burst
    do_reset();
    m_arvalid = 2'b01; m_arlen[7:0] = 8'd3; m_rready = 2'b01; s_rvalid = 1'b1;
    wait_grant(5, "t5");
    m_arvalid = 2'b00;
    b0 = nb0;
    n = 0;
    while (nb0 - b0 < 1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t5_one_beat", nb0 - b0, 1);
    reset = 1'b0;
    #1;
    chk("t5_rst_s_rready", s_rready, 0);
    chk("t5_rst_rvalid", m_rvalid, 2'b00);
    @(negedge clk);
    chk("t5_grant", grant, 2'b00);
    chk("t5_rvalid", m_rvalid, 2'b00);
    chk("t5_s_rready", s_rready, 0);
    chk("t5_s_arvalid", s_arvalid, 0);
    chk("t5_arready", m_arready, 2'b00);
    chk("t5_beats", nb0 - b0, 1);
    reset = 1'b1;
    m_arvalid = 2'b10; m_araddr[63:32] = 32'h200; m_arlen[15:8] = 8'd1;
    m_rready = 2'b10;
    wait_grant(5, "t5b");
    chk("t5b_grant", grant, 2'b10);
    chk("t5b_addr", s_araddr, 32'h200);
    m_arvalid = 2'b00;
    b1 = nb1;
    wait_idle(20, "t5b");
    chk("t5b_beats", nb1 - b1, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
